// File: rtl/ysyx_22041207_mul_iter.sv
// ysyx_22041207_mul_iter: iterative shift-add multiplier, responder side of the
// ALU multiply valid/ready handshake. Operands are reduced to magnitudes on
// accept, one multiplier bit is consumed per BUSY cycle, and the sign is
// re-applied over the full 2*XLEN product when the result is registered.
module ysyx_22041207_mul_iter #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned WLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mul_valid,
    input  logic            flush,
    input  logic            mulw,
    input  logic [1:0]      mul_signed,
    input  logic [XLEN-1:0] multiplicand,
    input  logic [XLEN-1:0] multiplier,
    output logic            mul_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] result_hi,
    output logic [XLEN-1:0] result_lo
);

    localparam int unsigned PLEN = 2 * XLEN;
    localparam int unsigned CW   = $clog2(XLEN + 1);
    localparam int unsigned XPAD = XLEN - WLEN;

    localparam logic [XLEN-1:0] ONE_X = XLEN'(1);
    localparam logic [PLEN-1:0] ONE_P = PLEN'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic            ready_q,     ready_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] res_hi_q,    res_hi_d;
    logic [XLEN-1:0] res_lo_q,    res_lo_d;
    logic [PLEN-1:0] acc_q,       acc_d;
    logic [PLEN-1:0] mcand_q,     mcand_d;
    logic [XLEN-1:0] mplier_q,    mplier_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic            neg_q,       neg_d;
    logic            wop_q,       wop_d;

    // Operand conditioning: word select/extend, sign detect, magnitude.
    logic            a_sgn, b_sgn;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_ext, b_ext;
    logic [XLEN-1:0] a_abs, b_abs;

    // Signed result over the full product width.
    logic [PLEN-1:0] prod_c;
    logic [CW-1:0]   n_lim_c;

    assign mul_ready = ready_q;
    assign out_valid = out_valid_q;
    assign result_hi = res_hi_q;
    assign result_lo = res_lo_q;

    // Operand decode: 2'b11 is s*s, 2'b01 is s*u, anything else is u*u.
    always_comb begin
        a_sgn = mul_signed[0];
        b_sgn = (mul_signed == 2'b11);
        if (mulw) begin
            a_ext = {{XPAD{a_sgn & multiplicand[WLEN-1]}}, multiplicand[WLEN-1:0]};
            b_ext = {{XPAD{b_sgn & multiplier[WLEN-1]}},   multiplier[WLEN-1:0]};
        end else begin
            a_ext = multiplicand;
            b_ext = multiplier;
        end
        a_neg = a_sgn & a_ext[XLEN-1];
        b_neg = b_sgn & b_ext[XLEN-1];
        // Negating the most-negative value yields 2^(XLEN-1), correct as unsigned.
        a_abs = a_neg ? (~a_ext + ONE_X) : a_ext;
        b_abs = b_neg ? (~b_ext + ONE_X) : b_ext;
    end

    // Final sign application and iteration limit for the latched op width.
    always_comb begin
        prod_c  = neg_q ? (~acc_q + ONE_P) : acc_q;
        n_lim_c = wop_q ? CW'(WLEN) : CW'(XLEN);
    end

    // Next-state, datapath and output logic; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        res_hi_d    = res_hi_q;
        res_lo_d    = res_lo_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        wop_d       = wop_q;

        unique case (state_q)
            S_IDLE: begin
                if (mul_valid && ready_q) begin
                    state_d  = S_BUSY;
                    acc_d    = '0;
                    mcand_d  = {{XLEN{1'b0}}, a_abs};
                    mplier_d = b_abs;
                    cnt_d    = '0;
                    neg_d    = a_neg ^ b_neg;
                    wop_d    = mulw;
                end
            end
            S_BUSY: begin
                if (cnt_q == n_lim_c) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    if (wop_q) begin
                        res_hi_d = {XLEN{prod_c[WLEN-1]}};
                        res_lo_d = {{XPAD{prod_c[WLEN-1]}}, prod_c[WLEN-1:0]};
                    end else begin
                        res_hi_d = prod_c[PLEN-1:XLEN];
                        res_lo_d = prod_c[XLEN-1:0];
                    end
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = {mcand_q[PLEN-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[XLEN-1:1]};
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            res_hi_d    = res_hi_q;
            res_lo_d    = res_lo_q;
        end

        ready_d = (state_d == S_IDLE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q     <= 1'b0;
            out_valid_q <= 1'b0;
            res_hi_q    <= '0;
            res_lo_q    <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            wop_q       <= 1'b0;
        end else begin
            ready_q     <= ready_d;
            out_valid_q <= out_valid_d;
            res_hi_q    <= res_hi_d;
            res_lo_q    <= res_lo_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            wop_q       <= wop_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_mul_iter.sv
// Scoreboard bench for ysyx_22041207_mul_iter: the driver pushes expected
// results and due cycles, a negedge monitor pops and compares on out_valid.
module tb_ysyx_22041207_mul_iter;

    localparam int unsigned XLEN = 64;
    localparam int unsigned WLEN = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        mul_valid;
    logic        flush;
    logic        mulw;
    logic [1:0]  mul_signed;
    logic [63:0] multiplicand;
    logic [63:0] multiplier;
    logic        mul_ready;
    logic        out_valid;
    logic [63:0] result_hi;
    logic [63:0] result_lo;

    ysyx_22041207_mul_iter #(.XLEN(XLEN), .WLEN(WLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .mul_valid    (mul_valid),
        .flush        (flush),
        .mulw         (mulw),
        .mul_signed   (mul_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .mul_ready    (mul_ready),
        .out_valid    (out_valid),
        .result_hi    (result_hi),
        .result_lo    (result_lo)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        int unsigned due;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] last_hi  = '0;
    logic [63:0] last_lo  = '0;
    int unsigned acc_cyc  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: exact product of the extended operands, modulo 2^128.
    function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] s, input logic w);
        logic [127:0] ea, eb, p;
        logic         sa, sb;
        sa = s[0];
        sb = (s == 2'b11);
        if (w) begin
            ea = sa ? {{96{a[31]}}, a[31:0]} : {96'd0, a[31:0]};
            eb = sb ? {{96{b[31]}}, b[31:0]} : {96'd0, b[31:0]};
        end else begin
            ea = sa ? {{64{a[63]}}, a} : {64'd0, a};
            eb = sb ? {{64{b[63]}}, b} : {64'd0, b};
        end
        p = ea * eb;
        if (w) p = {{96{p[31]}}, p[31:0]};
        return p;
    endfunction

    // Monitor: every out_valid pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("result_hi", result_hi, mon_e.hi);
                chk("result_lo", result_lo, mon_e.lo);
                chk("latency_cycle", 64'(cyc), 64'(mon_e.due));
                last_hi = mon_e.hi;
                last_lo = mon_e.lo;
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int g = 0;
        while (!mul_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        ok = mul_ready;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 required=1 (cycle %0d)", cyc);
        end
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [1:0] s,
                         input logic w, input logic [63:0] eh, input logic [63:0] el);
        bit   ok;
        exp_t e;
        @(negedge clk);
        wait_ready(ok);
        if (!ok) return;
        mul_valid    = 1'b1;
        multiplicand = a;
        multiplier   = b;
        mul_signed   = s;
        mulw         = w;
        acc_cyc      = cyc + 1;
        e.hi  = eh;
        e.lo  = el;
        e.due = acc_cyc + (w ? WLEN : XLEN) + 1;
        sbq.push_back(e);
        @(negedge clk);
        mul_valid = 1'b0;
        chk("ready_low_busy", 64'(mul_ready), 64'(0));
    endtask

    task automatic op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] s,
                      input logic w);
        logic [127:0] p;
        p = model(a, b, s, w);
        issue(a, b, s, w, p[127:64], p[63:0]);
    endtask

    task automatic drain();
        int g = 0;
        while (sbq.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL result_timeout pending=%0d required=0", sbq.size());
            sbq.delete();
        end
        @(negedge clk);
    endtask

    function automatic logic [63:0] rnd_op();
        logic [63:0] v;
        case ($urandom_range(0, 6))
            0:       v = 64'd0;
            1:       v = '1;
            2:       v = 64'h8000_0000_0000_0000;
            3:       v = 64'h0000_0000_8000_0000;
            4:       v = {32'd0, 32'($urandom)};
            default: v = {32'($urandom), 32'($urandom)};
        endcase
        return v;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [127:0] p1, p2;
        int unsigned  a1;
        bit           ok;
        exp_t         e;

        rst = 1'b0; mul_valid = 1'b0; flush = 1'b0; mulw = 1'b0;
        mul_signed = 2'b00; multiplicand = '0; multiplier = '0;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_result_hi", result_hi, 64'd0);
        chk("rst_result_lo", result_lo, 64'd0);
        chk("rst_ready", 64'(mul_ready), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(mul_ready), 64'(1));

        // Directed products with hand-derived results.
        issue(64'd3, 64'd5, 2'b00, 1'b0, 64'd0, 64'hF); drain();
        issue(-64'sd2, 64'd3, 2'b11, 1'b0, '1, 64'hFFFF_FFFF_FFFF_FFFA); drain();
        issue('1, '1, 2'b11, 1'b0, 64'd0, 64'd1); drain();
        issue('1, '1, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1); drain();
        issue('1, 64'd2, 2'b01, 1'b0, '1, 64'hFFFF_FFFF_FFFF_FFFE); drain();
        issue('1, 64'd2, 2'b10, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE); drain();
        issue(64'h7FFF_FFFF, 64'd2, 2'b11, 1'b1, '1, 64'hFFFF_FFFF_FFFF_FFFE); drain();
        issue(64'h8000_0000_0000_0000, '1, 2'b11, 1'b0, 64'd0, 64'h8000_0000_0000_0000); drain();
        issue(64'd0, -64'sd5, 2'b11, 1'b0, 64'd0, 64'd0); drain();
        issue(64'hDEAD_0000_FFFF_FFFF, 64'h1234_0000_0000_0003, 2'b11, 1'b1,
              '1, 64'hFFFF_FFFF_FFFF_FFFD); drain();

        // Flush in the middle of BUSY: no pulse, results held, ready next cycle.
        issue(64'd9, 64'd9, 2'b00, 1'b0, 64'd0, 64'd81);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        sbq.delete();
        @(negedge clk);
        flush = 1'b0;
        chk("flush_ready", 64'(mul_ready), 64'(1));
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        chk("flush_hold_hi", result_hi, last_hi);
        chk("flush_hold_lo", result_lo, last_lo);
        repeat (80) @(negedge clk);
        op(64'd11, 64'd13, 2'b00, 1'b0); drain();

        // Flush exactly on the BUSY->DONE edge suppresses the pulse.
        issue(64'd4, 64'd4, 2'b00, 1'b0, 64'd0, 64'd16);
        while (cyc < acc_cyc + XLEN) @(negedge clk);
        flush = 1'b1;
        sbq.delete();
        @(negedge clk);
        flush = 1'b0;
        chk("flush_done_out_valid", 64'(out_valid), 64'(0));
        chk("flush_done_lo_hold", result_lo, last_lo);
        repeat (5) @(negedge clk);

        // Flush together with a request in IDLE: not accepted.
        mul_valid = 1'b1; flush = 1'b1; multiplicand = 64'd2; multiplier = 64'd2;
        @(negedge clk);
        mul_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_not_accepted", 64'(mul_ready), 64'(1));
        repeat (70) @(negedge clk);

        // Reset mid-BUSY: immediate clear, then a normal op.
        issue(64'd100, 64'd100, 2'b00, 1'b0, 64'd0, 64'd10000);
        repeat (20) @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_hi", result_hi, 64'd0);
        chk("midrst_lo", result_lo, 64'd0);
        chk("midrst_ready", 64'(mul_ready), 64'(0));
        last_hi = '0;
        last_lo = '0;
        @(negedge clk);
        rst = 1'b1;
        issue(64'd7, 64'd6, 2'b00, 1'b0, 64'd0, 64'd42); drain();

        // Back-to-back with mul_valid held high.
        p1 = model(64'h1_0000_0001, 64'h3, 2'b00, 1'b0);
        p2 = model(-64'sd7, 64'd9, 2'b11, 1'b1);
        @(negedge clk);
        wait_ready(ok);
        if (ok) begin
            mul_valid = 1'b1; mulw = 1'b0; mul_signed = 2'b00;
            multiplicand = 64'h1_0000_0001; multiplier = 64'h3;
            a1 = cyc + 1;
            e.hi = p1[127:64]; e.lo = p1[63:0]; e.due = a1 + XLEN + 1;
            sbq.push_back(e);
            @(negedge clk);
            mulw = 1'b1; mul_signed = 2'b11; multiplicand = -64'sd7; multiplier = 64'd9;
            wait_ready(ok);
            chk("b2b_second_accept_cycle", 64'(cyc + 1), 64'(a1 + XLEN + 3));
            e.hi = p2[127:64]; e.lo = p2[63:0]; e.due = cyc + 1 + WLEN + 1;
            sbq.push_back(e);
            @(negedge clk);
            mul_valid = 1'b0;
            repeat (5) @(negedge clk);
            chk("b2b_hold_hi", result_hi, p1[127:64]);
            chk("b2b_hold_lo", result_lo, p1[63:0]);
        end
        drain();

        // Randomized products against the reference model.
        for (int i = 0; i < 40; i++) begin
            op(rnd_op(), rnd_op(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
